arbitro_sumador: RTL and testbench
==================================

# arbitro_sumador

Round-robin arbiter that shares one pipelined 4-bit adder (`sumador`) between four requesters. It accepts one operand pair per cycle from the winning requester, drives the adder's `dataA`/`dataB` inputs, and carries a valid/ID tag alongside the adder pipeline. Each result leaves on a response port labelled with the originating requester. It sits between the requester logic and the `sumador` instance in the datapath top level.

## Interface
Parameters:
- `WIDTH`, 4: operand and sum width.
- `LAT`, 2: adder register stages, from operands present at adder input to `sum30_dd` valid.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset_L`  in  1: asynchronous, active-low reset.
- `req_valid`  in  4: request from requester i on bit i.
- `req_dataA`  in  4*WIDTH: operand A, requester i on bits [i*WIDTH +: WIDTH].
- `req_dataB`  in  4*WIDTH: operand B, same packing as `req_dataA`.
- `hold`  in  1: when 1, no new grants are issued.
- `grant`  out  4: one-hot (or zero), combinational; requester i's operands are accepted at this edge.
- `dataA`  out  WIDTH: registered; drives the adder's A input.
- `dataB`  out  WIDTH: registered; drives the adder's B input.
- `sum30_dd`  in  WIDTH: adder result.
- `rsp_valid`  out  1: response valid this cycle.
- `rsp_id`  out  2: requester index of the response.
- `rsp_sum`  out  WIDTH: equals `sum30_dd` when `rsp_valid`=1, otherwise 0.
- `busy`  out  1: 1 when state != IDLE.
- `done_count`  out  8: number of responses delivered; wraps modulo 256.

## Operation
- **Arbitration**
  - Priority pointer `ptr` (2 bits). Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first asserted `req_valid` bit wins and gets `grant`, unless `hold`=1.
  - After a grant to requester i, `ptr` becomes (i+1) mod 4. With no grant, `ptr` is unchanged.
- **Handshake**
  - A requester keeps `req_valid` and its operands stable until it sees its `grant` bit at a rising edge.
  - `grant` depends combinationally on `req_valid`, `hold` and `ptr`.
- **Issue**
  - On a granted edge: `dataA`/`dataB` load the winner's operands, and tag stage 0 loads {valid=1, id=i}.
  - With no grant: `dataA`/`dataB` load 0 and tag stage 0 loads valid=0.
- **Tag pipeline**
  - LAT+1 stages; stage k+1 loads stage k every cycle.
  - The last stage drives `rsp_valid`/`rsp_id`. The adder never stalls, and responses have no ready signal.
- **Arithmetic**
  - `rsp_sum` = (A+B) mod 2^WIDTH. The carry is discarded, as the adder provides it.
- **Count**
  - `done_count` increments on every cycle with `rsp_valid`=1; it wraps from 255 to 0.
- **States**
  - IDLE: no tag stage valid and no grant.
  - ACTIVE: a grant this cycle or any tag stage valid, with `hold`=0.
  - DRAIN: `hold`=1 while any tag stage is valid.
  - Transitions:
    - IDLE→ACTIVE on a grant.
    - ACTIVE→DRAIN when `hold` rises with ops in flight.
    - DRAIN→ACTIVE when `hold` falls and requests are present.
    - ACTIVE/DRAIN→IDLE when the pipeline is empty and there is no grant.
- **Reset** (`reset_L`=0, asynchronous, takes effect immediately)
  - Cleared to 0: `ptr`, all tag stages, `dataA`, `dataB`, `done_count`, `rsp_valid`, `rsp_id`, `rsp_sum`, `busy`. State returns to IDLE.
  - `grant`=0 while reset is asserted.
  - Operations in flight are dropped; no response is produced for them.

## Timing
- Grant at edge E (cycle t): operands appear on `dataA`/`dataB` in cycle t+1.
- The response is valid in cycle t+1+LAT, which is t+3 at the default LAT=2.
- Throughput is one operation per cycle. Back-to-back grants give back-to-back responses in grant order.
- `hold` asserted in cycle t blocks a grant in cycle t. Ops already granted still complete.
- Simultaneous requests are served in rotating order; no requester waits more than 3 grants.
- `busy` is registered from the state and updates on the edge after the condition changes.
- Reset released mid-stream: first grant possible in the first cycle with `reset_L`=1, with `ptr`=0.

## Test plan
- **Single request:** reset, then `req_valid`=0001 with A=3, B=4.
  - Required: `grant`=0001 in the request cycle.
  - Required: 3 cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=7, then `done_count`=1.
- **Round-robin:** all four requesters held valid with A=i, B=1 for 8 cycles.
  - Required: grants in order 0,1,2,3,0,1,2,3.
  - Required: responses with ids 0,1,2,3,0,1,2,3 and sums 1,2,3,4,1,2,3,4 on consecutive cycles.
- **Overflow wrap:** A=15, B=3.
  - Required: `rsp_sum`=2.
  - Then 256 responses in total; required: `done_count` reads 0.
- **Hold/drain:** two grants issued, then `hold`=1 with all requests valid.
  - Required: no further grants, both responses delivered, state DRAIN then IDLE, `busy` falls.
  - `hold`=0: required: grants resume from `ptr`.
- **Reset mid-flight:** grant issued, `reset_L` pulsed low 1 cycle later.
  - Required: `rsp_valid` stays 0 and `done_count`=0.
  - After release: `ptr`=0, so requester 0 wins over 2 when both request.
- **Fairness with a sparse requester:** requester 1 asserts once while 0 and 3 are continuously valid.
  - Required: requester 1 is granted within 3 cycles.

Source files
------------

// File: rtl/arbitro_sumador.sv
// arbitro_sumador: round-robin arbiter sharing one pipelined adder among four
// requesters. The winner's operands are registered onto dataA/dataB, and a
// {valid, id} tag travels alongside the adder pipeline so that each sum leaves
// on the response port labelled with the requester that issued it.
//
// Ports:
//   clk, reset_L        clock, asynchronous active-low reset
//   req_valid[3:0]      request from requester i on bit i
//   req_dataA/B         operands, requester i on [i*WIDTH +: WIDTH]
//   hold                blocks new grants while 1
//   grant[3:0]          one-hot (or zero) combinational grant
//   dataA, dataB        registered adder operands
//   sum30_dd            adder result, LAT cycles after dataA/dataB
//   rsp_valid, rsp_id   response valid and originating requester
//   rsp_sum             sum30_dd while rsp_valid, otherwise 0
//   busy                registered, 1 while the controller is not idle
//   done_count          responses delivered, modulo 256
module arbitro_sumador #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [3:0]           req_valid,
    input  logic [4*WIDTH-1:0]   req_dataA,
    input  logic [4*WIDTH-1:0]   req_dataB,
    input  logic                 hold,
    output logic [3:0]           grant,
    output logic [WIDTH-1:0]     dataA,
    output logic [WIDTH-1:0]     dataB,
    input  logic [WIDTH-1:0]     sum30_dd,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [WIDTH-1:0]     rsp_sum,
    output logic                 busy,
    output logic [7:0]           done_count
);

    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDW    = 2;
    localparam int unsigned STAGES = LAT + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_nx;
    logic [IDW-1:0]              ptr;
    logic [STAGES-1:0]           tag_v;
    logic [STAGES-1:0][IDW-1:0]  tag_id;
    logic [IDW-1:0]              win_idx;
    logic                        win_found;
    logic                        grant_any;
    logic                        tag_any;

    // Rotating-priority search starting at ptr; the index wraps in 2 bits.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_valid[ptr + IDW'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr + IDW'(k);
            end
        end
        if (reset_L && !hold && win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign grant_any = |grant;
    assign tag_any   = |tag_v;

    // Controller next state: track whether work is being issued or drained.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (grant_any) state_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (hold && tag_any)               state_nx = ST_DRAIN;
                else if (!grant_any && !tag_any)   state_nx = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!grant_any && !tag_any)        state_nx = ST_IDLE;
                else if (!hold)                    state_nx = ST_ACTIVE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register; busy mirrors the state that is being entered.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != ST_IDLE);
        end
    end

    // Operand issue, priority pointer and tag pipeline.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr    <= '0;
            dataA  <= '0;
            dataB  <= '0;
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            if (grant_any) begin
                ptr   <= win_idx + IDW'(1);
                dataA <= req_dataA[win_idx*WIDTH +: WIDTH];
                dataB <= req_dataB[win_idx*WIDTH +: WIDTH];
            end else begin
                dataA <= '0;
                dataB <= '0;
            end
            tag_v[0]  <= grant_any;
            tag_id[0] <= grant_any ? win_idx : '0;
            for (int k = 1; k < STAGES; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Delivered-response counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            done_count <= '0;
        end else if (rsp_valid) begin
            done_count <= done_count + 8'd1;
        end
    end

    // The last tag stage lines up with sum30_dd; the sum is masked when idle.
    assign rsp_valid = tag_v[STAGES-1];
    assign rsp_id    = tag_id[STAGES-1];
    assign rsp_sum   = rsp_valid ? sum30_dd : '0;

endmodule

// File: tb/tb_arbitro_sumador.sv
// Bench for arbitro_sumador: directed scenarios plus a random phase. A
// reference arbiter predicts each grant and queues the expected response;
// an independent monitor pops the queue whenever the DUT responds.
module tb_arbitro_sumador;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned LAT   = 2;

    logic              clk = 1'b0;
    logic              reset_L = 1'b1;
    logic [3:0]        req_valid = '0;
    logic [4*WIDTH-1:0] req_dataA = '0;
    logic [4*WIDTH-1:0] req_dataB = '0;
    logic              hold = 1'b0;
    logic [3:0]        grant;
    logic [WIDTH-1:0]  dataA, dataB, sum30_dd;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [WIDTH-1:0]  rsp_sum;
    logic              busy;
    logic [7:0]        done_count;

    arbitro_sumador #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .reset_L(reset_L), .req_valid(req_valid),
        .req_dataA(req_dataA), .req_dataB(req_dataB), .hold(hold),
        .grant(grant), .dataA(dataA), .dataB(dataB), .sum30_dd(sum30_dd),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    // Behavioural two-stage adder standing in for sumador.
    logic [WIDTH-1:0] s1 = '0, s2 = '0;
    always @(posedge clk) begin
        s1 <= WIDTH'(dataA + dataB);
        s2 <= s1;
    end
    assign sum30_dd = s2;

    typedef struct {
        logic [1:0] id;
        logic [3:0] sum;
        int         due;
    } exp_t;

    exp_t       sbq[$];
    int         gnt_log[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         mptr = 0;
    logic [7:0] mcount = '0;
    logic [3:0] last_gnt = '0;

    logic       rv [4];
    logic [3:0] ra [4];
    logic [3:0] rb [4];
    logic [3:0] cont = '0;
    bit         reroll = 0;
    bit         rnd_mode = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference arbiter: predict grant, queue expected response.
    always @(negedge clk) begin : sb_proc
        logic [3:0] eg;
        int         w;
        exp_t       e;
        eg = '0;
        w  = -1;
        if (!reset_L) begin
            sbq.delete();
            mptr = 0;
        end else if (!hold) begin
            for (int k = 0; k < 4; k++)
                if (w < 0 && req_valid[(mptr + k) % 4]) w = (mptr + k) % 4;
        end
        if (w >= 0) eg[w] = 1'b1;
        check(grant === eg, "grant", int'(grant), int'(eg));
        last_gnt = eg;
        for (int i = 0; i < 4; i++) if (grant[i]) gnt_log.push_back(i);
        if (w >= 0) begin
            e.id  = 2'(w);
            e.sum = 4'(req_dataA[w*4 +: 4] + req_dataB[w*4 +: 4]);
            e.due = cyc + 1 + int'(LAT);
            sbq.push_back(e);
            mptr = (w + 1) % 4;
        end
    end

    // Monitor: compare every DUT response against the queue head.
    always @(negedge clk) begin : mon_proc
        exp_t e;
        if (!reset_L) begin
            mcount = '0;
            check(rsp_valid === 1'b0 && busy === 1'b0 && done_count === 8'd0 && dataA === 4'd0,
                  "reset_outputs", int'({rsp_valid, busy}), 0);
        end else begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                check(1'b0, "missing_rsp", 0, int'(e.id));
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    check(1'b0, "unexpected_rsp", int'(rsp_id), -1);
                end else begin
                    e = sbq.pop_front();
                    check(rsp_id === e.id, "rsp_id", int'(rsp_id), int'(e.id));
                    check(rsp_sum === e.sum, "rsp_sum", int'(rsp_sum), int'(e.sum));
                    check(e.due == cyc, "rsp_latency", cyc, e.due);
                    check(done_count === mcount, "done_count", int'(done_count), int'(mcount));
                end
                mcount = mcount + 8'd1;
            end else begin
                check(rsp_sum === 4'd0, "rsp_sum_idle", int'(rsp_sum), 0);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = rv[i];
            req_dataA[i*4 +: 4] = ra[i];
            req_dataB[i*4 +: 4] = rb[i];
        end
    endtask

    // Advance one cycle; granted requesters drop or re-arm, random mode refills.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (last_gnt[i]) begin
                if (cont[i]) begin
                    if (reroll) begin
                        ra[i] = 4'($urandom_range(0, 15));
                        rb[i] = 4'($urandom_range(0, 15));
                    end
                end else begin
                    rv[i] = 1'b0;
                end
            end
        end
        if (rnd_mode) begin
            for (int i = 0; i < 4; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = 4'($urandom_range(0, 15));
                    rb[i] = 4'($urandom_range(0, 15));
                end
            end
            hold = ($urandom_range(0, 7) == 0);
        end
        drive();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) begin
            rv[i] = 1'b0;
            ra[i] = '0;
            rb[i] = '0;
        end
        cont = '0;
        drive();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        hold    = 1'b0;
        clear_reqs();
        repeat (3) @(posedge clk);
        #1;
        reset_L = 1'b1;
        gnt_log.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        bit got;
        int n;
        clear_reqs();
        #2;
        // Single request: 3 + 4 from requester 0.
        do_reset();
        rv[0] = 1'b1; ra[0] = 4'd3; rb[0] = 4'd4;
        drive();
        @(negedge clk);
        check(grant === 4'b0001, "single_grant", int'(grant), 1);
        repeat (6) tick();
        check(done_count === 8'd1, "single_done", int'(done_count), 1);

        // Round-robin: all four requesters held valid with A=i, B=1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rv[i] = 1'b1; ra[i] = 4'(i); rb[i] = 4'd1;
        end
        cont = 4'b1111;
        drive();
        repeat (8) tick();
        clear_reqs();
        repeat (6) tick();
        check(gnt_log.size() == 8, "rr_count", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            check(gnt_log[i] == i % 4, "rr_order", gnt_log[i], i % 4);

        // Overflow: 15 + 3 wraps to 2, then stream to 256 responses.
        do_reset();
        rv[2] = 1'b1; ra[2] = 4'd15; rb[2] = 4'd3;
        drive();
        tick();
        repeat (3) @(negedge clk);
        check(rsp_valid === 1'b1 && rsp_sum === 4'd2, "overflow_sum", int'(rsp_sum), 2);
        for (int i = 0; i < 4; i++) begin
            rv[i] = 1'b1; ra[i] = 4'($urandom_range(0, 15)); rb[i] = 4'($urandom_range(0, 15));
        end
        cont = 4'b1111;
        reroll = 1;
        drive();
        repeat (255) tick();
        reroll = 0;
        clear_reqs();
        repeat (6) tick();
        check(done_count === 8'd0, "count_wrap", int'(done_count), 0);

        // Hold/drain: two grants, then hold with all requests pending.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rv[i] = 1'b1; ra[i] = 4'(i + 5); rb[i] = 4'(2 * i);
        end
        cont = 4'b1111;
        drive();
        tick();
        tick();
        hold = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check(grant === 4'b0000, "hold_grant", int'(grant), 0);
            if (j == 0) check(busy === 1'b1, "drain_busy", int'(busy), 1);
            tick();
        end
        @(negedge clk);
        check(busy === 1'b0, "drain_idle", int'(busy), 0);
        tick();
        hold = 1'b0;
        @(negedge clk);
        check(grant === 4'b0100, "hold_resume", int'(grant), 4);
        tick();
        clear_reqs();
        repeat (6) tick();

        // Reset mid-flight: in-flight op dropped, ptr returns to 0.
        do_reset();
        rv[1] = 1'b1; ra[1] = 4'd5; rb[1] = 4'd6;
        drive();
        tick();
        #1 reset_L = 1'b0;
        @(posedge clk);
        #1 reset_L = 1'b1;
        rv[0] = 1'b1; ra[0] = 4'd1; rb[0] = 4'd1;
        rv[2] = 1'b1; ra[2] = 4'd2; rb[2] = 4'd2;
        drive();
        @(negedge clk);
        check(grant === 4'b0001, "reset_ptr", int'(grant), 1);
        tick();
        @(negedge clk);
        check(rsp_valid === 1'b0, "reset_drop", int'(rsp_valid), 0);
        check(done_count === 8'd0, "reset_count", int'(done_count), 0);
        repeat (6) tick();

        // Fairness: requester 1 asserts once among busy 0 and 3.
        do_reset();
        rv[0] = 1'b1; ra[0] = 4'd7; rb[0] = 4'd7;
        rv[3] = 1'b1; ra[3] = 4'd9; rb[3] = 4'd1;
        cont = 4'b1001;
        drive();
        tick();
        tick();
        rv[1] = 1'b1; ra[1] = 4'd12; rb[1] = 4'd12;
        drive();
        got = 0;
        n   = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            n++;
            if (grant[1]) got = 1;
            tick();
        end
        check(got && n <= 3, "fair_wait", n, 3);
        clear_reqs();
        repeat (6) tick();

        // Random traffic with occasional hold.
        do_reset();
        rnd_mode = 1;
        repeat (400) tick();
        rnd_mode = 0;
        hold = 1'b0;
        clear_reqs();
        repeat (8) tick();
        check(sbq.size() == 0, "queue_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
